// File: rtl/combat_health_arbiter.sv
// Two-player health/round arbiter: damage with invulnerability windows, KO/draw hold, match win tracking.
// Optional regeneration is compiled in only when the REGEN_EN macro is defined.
module combat_health_arbiter #(
    parameter int HP_W          = 9,
    parameter int HP_MAX        = 200,
    parameter int DMG_LIGHT     = 4,
    parameter int DMG_MED       = 10,
    parameter int DMG_HEAVY     = 40,
    parameter int INVULN_TICKS  = 8,
    parameter int KO_TICKS      = 16,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int REGEN_PERIOD  = 60
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            tick,
    input  logic            p1_hit,
    input  logic            p2_hit,
    input  logic [1:0]      attack_state1,
    input  logic [1:0]      attack_state2,
    output logic [HP_W-1:0] health_1,
    output logic [HP_W-1:0] health_2,
    output logic [1:0]      wins_1,
    output logic [1:0]      wins_2,
    output logic [2:0]      state,
    output logic            round_end
);

    localparam int INV_W = $clog2(INVULN_TICKS + 1);
    localparam int KO_W  = $clog2(KO_TICKS + 1);

    localparam logic [HP_W-1:0]  HP_FULL  = HP_W'(HP_MAX);
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_TICKS);
    localparam logic [KO_W-1:0]  KO_LAST  = KO_W'(KO_TICKS - 1);
    localparam logic [1:0]       WIN_TGT  = 2'(ROUNDS_TO_WIN);

    typedef enum logic [2:0] {
        S_IDLE       = 3'b000,
        S_FIGHT      = 3'b001,
        S_KO_P1      = 3'b010,
        S_KO_P2      = 3'b011,
        S_DRAW       = 3'b100,
        S_MATCH_OVER = 3'b101
    } state_t;

    state_t           state_q, state_d;
    logic [HP_W-1:0]  health1_q, health1_d, health2_q, health2_d;
    logic [1:0]       wins1_q, wins1_d, wins2_q, wins2_d;
    logic [INV_W-1:0] inv1_q, inv1_d, inv2_q, inv2_d;
    logic [KO_W-1:0]  ko_cnt_q, ko_cnt_d;
    logic             round_end_q, round_end_d;
    logic             acc1, acc2;

`ifdef REGEN_EN
    localparam int RG_W = $clog2(REGEN_PERIOD + 1);
    localparam logic [RG_W-1:0] RG_LAST = RG_W'(REGEN_PERIOD - 1);
    logic [RG_W-1:0] regen_q, regen_d;
    logic            regen_step;
`endif

    function automatic logic [HP_W-1:0] dmg_of(input logic [1:0] code);
        case (code)
            2'b01:   return HP_W'(DMG_LIGHT);
            2'b10:   return HP_W'(DMG_MED);
            2'b11:   return HP_W'(DMG_HEAVY);
            default: return '0;
        endcase
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] h, input logic [HP_W-1:0] d);
        return (h > d) ? h - d : '0;
    endfunction

    always_comb begin
        state_d     = state_q;
        health1_d   = health1_q;
        health2_d   = health2_q;
        wins1_d     = wins1_q;
        wins2_d     = wins2_q;
        inv1_d      = inv1_q;
        inv2_d      = inv2_q;
        ko_cnt_d    = ko_cnt_q;
        round_end_d = 1'b0;
        acc1        = 1'b0;
        acc2        = 1'b0;
`ifdef REGEN_EN
        regen_d     = '0;
        regen_step  = 1'b0;
`endif

        if (tick && inv1_q != '0) inv1_d = inv1_q - INV_W'(1);
        if (tick && inv2_q != '0) inv2_d = inv2_q - INV_W'(1);

        case (state_q)
            S_IDLE: begin
                health1_d = '0;
                health2_d = '0;
                wins1_d   = '0;
                wins2_d   = '0;
                if (start) begin
                    state_d   = S_FIGHT;
                    health1_d = HP_FULL;
                    health2_d = HP_FULL;
                    inv1_d    = '0;
                    inv2_d    = '0;
                end
            end
            S_FIGHT: begin
                // Exit looks at registered health, so the cycle after the killing blow ends the round.
                if (health1_q == '0 || health2_q == '0) begin
                    round_end_d = 1'b1;
                    ko_cnt_d    = '0;
                    if (health1_q == '0 && health2_q == '0) begin
                        state_d = S_DRAW;
                    end else if (health2_q == '0) begin
                        state_d = S_KO_P1;
                        wins1_d = wins1_q + 2'd1;
                    end else begin
                        state_d = S_KO_P2;
                        wins2_d = wins2_q + 2'd1;
                    end
                end else begin
                    acc2 = p1_hit && attack_state1 != 2'b00 && inv2_q == '0;
                    acc1 = p2_hit && attack_state2 != 2'b00 && inv1_q == '0;
                    if (acc2) begin
                        health2_d = sat_sub(health2_q, dmg_of(attack_state1));
                        inv2_d    = INV_LOAD;
                    end
                    if (acc1) begin
                        health1_d = sat_sub(health1_q, dmg_of(attack_state2));
                        inv1_d    = INV_LOAD;
                    end
`ifdef REGEN_EN
                    regen_d = regen_q;
                    if (tick) begin
                        if (regen_q == RG_LAST) begin
                            regen_d    = '0;
                            regen_step = 1'b1;
                        end else begin
                            regen_d = regen_q + RG_W'(1);
                        end
                    end
                    // A hit on the same edge wins over regeneration.
                    if (regen_step && !acc1 && inv1_q == '0 && health1_q < HP_FULL)
                        health1_d = health1_q + HP_W'(1);
                    if (regen_step && !acc2 && inv2_q == '0 && health2_q < HP_FULL)
                        health2_d = health2_q + HP_W'(1);
`endif
                end
            end
            S_KO_P1, S_KO_P2, S_DRAW: begin
                if (tick) begin
                    if (ko_cnt_q == KO_LAST) begin
                        if (wins1_q == WIN_TGT || wins2_q == WIN_TGT) begin
                            state_d = S_MATCH_OVER;
                        end else begin
                            state_d   = S_FIGHT;
                            health1_d = HP_FULL;
                            health2_d = HP_FULL;
                            inv1_d    = '0;
                            inv2_d    = '0;
                        end
                    end else begin
                        ko_cnt_d = ko_cnt_q + KO_W'(1);
                    end
                end
            end
            S_MATCH_OVER: begin
                if (start) begin
                    state_d   = S_FIGHT;
                    wins1_d   = '0;
                    wins2_d   = '0;
                    health1_d = HP_FULL;
                    health2_d = HP_FULL;
                    inv1_d    = '0;
                    inv2_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            health1_q   <= '0;
            health2_q   <= '0;
            wins1_q     <= '0;
            wins2_q     <= '0;
            inv1_q      <= '0;
            inv2_q      <= '0;
            ko_cnt_q    <= '0;
            round_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            health1_q   <= health1_d;
            health2_q   <= health2_d;
            wins1_q     <= wins1_d;
            wins2_q     <= wins2_d;
            inv1_q      <= inv1_d;
            inv2_q      <= inv2_d;
            ko_cnt_q    <= ko_cnt_d;
            round_end_q <= round_end_d;
        end
    end

`ifdef REGEN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) regen_q <= '0;
        else        regen_q <= regen_d;
    end
`endif

    assign health_1  = health1_q;
    assign health_2  = health2_q;
    assign wins_1    = wins1_q;
    assign wins_2    = wins2_q;
    assign state     = state_q;
    assign round_end = round_end_q;

endmodule
